regfile_mp: RTL and testbench
=============================

# regfile_mp

Multi-port, parametrised register file for the NPC core: the next generation of the single-write, two-read register array. It adds a configurable number of read ports, two write ports with fixed priority, an optional hard-wired zero register, and optional write-to-read bypass. It also adds a hardware clear sequencer that sweeps every entry to zero after reset or on request. It sits between decode (read ports) and writeback (write ports); `ready` gates issue.

## Interface
- `ADDR_WIDTH`, default 5: index width; depth = 2**ADDR_WIDTH entries.
- `DATA_WIDTH`, default 64: entry width.
- `NR_RD`, default 2: number of read ports, minimum 1.
- `ZERO_REG`, default 1: 1 = entry 0 reads as 0 and writes to it are dropped.
- `BYPASS`, default 1: 1 = a read of an address being written this cycle returns the write data.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `clr` in 1: request a full clear sweep; single-cycle pulse or level.
- `wen0` in 1: write port 0 enable.
- `waddr0` in ADDR_WIDTH: write port 0 address.
- `wdata0` in DATA_WIDTH: write port 0 data.
- `wen1` in 1: write port 1 enable; port 1 has priority over port 0.
- `waddr1` in ADDR_WIDTH: write port 1 address.
- `wdata1` in DATA_WIDTH: write port 1 data.
- `raddr` in NR_RD*ADDR_WIDTH: read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `rdata` out NR_RD*DATA_WIDTH: read data, same packing as `raddr`.
- `ready` out 1: 1 = array valid and accepting writes.

## Operation
- FSM states:
  - CLEAR: `ready`=0. A sweep counter `cnt` (ADDR_WIDTH bits) writes 0 to entry `cnt` each cycle and increments. When the sweep writes the last entry (`cnt`=2**ADDR_WIDTH-1), the next state is IDLE.
  - IDLE: `ready`=1. Normal operation.
- Transitions:
  - `rst_n`=0 in any state: next state CLEAR, `cnt`=0.
  - `clr`=1 in IDLE: next state CLEAR, `cnt`=0.
  - `clr`=1 in CLEAR: `cnt` restarts at 0.
- Writes are ignored while `ready`=0. In a cycle where `clr`=1 in IDLE, writes are also ignored.
- Writes in IDLE:
  - Port 0 writes `wdata0` to `waddr0` when `wen0`=1.
  - Port 1 writes `wdata1` to `waddr1` when `wen1`=1.
  - Both enabled to the same address: only `wdata1` is stored.
  - With `ZERO_REG`=1, writes to address 0 are dropped on either port.
- Reads are combinational, evaluated independently per port. Priority, highest first:
  - `ready`=0: return 0.
  - `ZERO_REG`=1 and address 0: return 0.
  - `BYPASS`=1, `wen1`=1, addresses match, write effective: return `wdata1`.
  - `BYPASS`=1, `wen0`=1, addresses match, write effective: return `wdata0`.
  - Otherwise: return the stored entry.
  - "Write effective" means the write would actually be stored this cycle: IDLE, `clr`=0, and not dropped by `ZERO_REG`.
- With `BYPASS`=0, a read in the same cycle as a write to the same address returns the old value.
- Entries have no reset of their own; the sweep is the only clearing mechanism.

## Timing
- Reset values, asserted on the first edge with `rst_n`=0:
  - `ready`=0.
  - All `rdata` lanes read 0.
  - `cnt`=0, state CLEAR.
- Clear latency:
  - After `rst_n` rises, the sweep takes 2**ADDR_WIDTH cycles.
  - `ready` reads 1 starting at cycle 2**ADDR_WIDTH after the first edge with `rst_n`=1; that is cycle 32 for the defaults.
  - A `clr` in IDLE produces the same 2**ADDR_WIDTH-cycle low window on `ready`, starting the cycle after `clr` is sampled.
- Write latency: an effective write at edge N is visible on the stored path from cycle N+1.
- `rst_n` low mid-sweep aborts the sweep; the sweep restarts from 0 after release.
- `rst_n` low has priority over `clr` and writes.
- Reads have no latency; `rdata` is purely combinational from `raddr`, write ports, and state.

## Test plan
- **Reset sweep:** hold `rst_n`=0 for 3 cycles, release → `ready`=0 for exactly 32 cycles, then 1; reading any address afterwards returns 0.
- **Dual write and read:** `ready`=1, write 0xDEAD to r5 on port 0 and 0xBEEF to r7 on port 1 in the same cycle → next cycle, `raddr` {5,7} returns {0xDEAD, 0xBEEF}.
- **Write collision:** `wen0`=`wen1`=1, both to r9, data 0x11 on port 0 and 0x22 on port 1 → same-cycle bypass read of r9 = 0x22; next-cycle stored read = 0x22.
- **Zero register:** write 0xFFFF to r0 on both ports → same-cycle and next-cycle reads of r0 = 0. With `ZERO_REG`=0 in a second build, next-cycle read = 0xFFFF (port 1 data).
- **Bypass off:** `BYPASS`=0, r3 holds 0x1, write 0x2 to r3 → same-cycle read = 0x1; next-cycle read = 0x2.
- **Clear mid-operation:** fill r1..r31, pulse `clr`, and assert `wen0` in the same cycle → that write is dropped; `ready`=0 for 32 cycles; all reads return 0 afterwards. Pulse `rst_n` low at sweep cycle 10 → `ready` stays 0 for 32 cycles after release.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two prioritised write ports,
// an optional hard-wired zero entry, optional write-to-read bypass and a
// clear sequencer that sweeps every entry to zero after reset or on request.
module regfile_mp #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NR_RD      = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          wen0,
  input  logic [ADDR_WIDTH-1:0]         waddr0,
  input  logic [DATA_WIDTH-1:0]         wdata0,
  input  logic                          wen1,
  input  logic [ADDR_WIDTH-1:0]         waddr1,
  input  logic [DATA_WIDTH-1:0]         wdata1,
  input  logic [NR_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NR_RD*DATA_WIDTH-1:0]   rdata,
  output logic                          ready
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_ok_c;
  logic we0_eff_c;
  logic we1_eff_c;

  // A write is effective only in IDLE with no clear request, and not to the zero entry
  assign wr_ok_c   = (state == S_IDLE) && !clr;
  assign we0_eff_c = wr_ok_c && wen0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign we1_eff_c = wr_ok_c && wen1 && !((ZERO_REG != 0) && (waddr1 == '0));

  // Clear sequencer: sweep counter, state and the registered ready flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (clr) begin
            cnt <= '0;
          end else if (cnt == LAST_IDX) begin
            state <= S_IDLE;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (clr) begin
            state <= S_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= S_CLEAR;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage: sweep clears one entry per cycle; port 1 is applied last so it wins a collision
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == S_CLEAR) begin
        mem[cnt] <= '0;
      end else begin
        if (we0_eff_c) mem[waddr0] <= wdata0;
        if (we1_eff_c) mem[waddr1] <= wdata1;
      end
    end
  end

  // Read ports: combinational, each lane resolved independently
  for (genvar i = 0; i < int'(NR_RD); i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;

    assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    // Priority: not ready, zero entry, port 1 bypass, port 0 bypass, stored value
    always_comb begin
      rd = mem[ra];
      if (!ready) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if ((BYPASS != 0) && we1_eff_c && (waddr1 == ra)) begin
        rd = wdata1;
      end else if ((BYPASS != 0) && we0_eff_c && (waddr0 == ra)) begin
        rd = wdata0;
      end
    end

    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default build (zero entry, bypass) and a build with
// both features off share the same stimulus and are checked side by side.
module tb_regfile_mp;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         wen0;
  logic [4:0]   waddr0;
  logic [63:0]  wdata0;
  logic         wen1;
  logic [4:0]   waddr1;
  logic [63:0]  wdata1;
  logic [9:0]   raddr;
  logic [127:0] rdata_a;
  logic [127:0] rdata_b;
  logic         ready_a;
  logic         ready_b;

  int checks = 0;
  int errors = 0;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_a), .ready(ready_a)
  );

  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_b), .ready(ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen0;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic        wen1;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] ea0;
    logic [63:0] ea1;
    logic [63:0] eb0;
    logic [63:0] eb1;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    clr  = 1'b0;
    wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
    wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
  endtask

  // Counts cycles with ready low, starting from the current (negedge) sample point
  task automatic measure_low(output int n);
    n = 0;
    while (ready_a !== 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [63:0] v;

    vecs[0]  = '{1'b1, 5'd5,  64'hDEAD, 1'b1, 5'd7,  64'hBEEF, 5'd5,  5'd7,
                 64'hDEAD, 64'hBEEF, 64'h0, 64'h0};
    vecs[1]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd5,  5'd7,
                 64'hDEAD, 64'hBEEF, 64'hDEAD, 64'hBEEF};
    vecs[2]  = '{1'b1, 5'd9,  64'h11,   1'b1, 5'd9,  64'h22,   5'd9,  5'd9,
                 64'h22, 64'h22, 64'h0, 64'h0};
    vecs[3]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd9,  5'd5,
                 64'h22, 64'hDEAD, 64'h22, 64'hDEAD};
    vecs[4]  = '{1'b1, 5'd0,  64'hFFFF, 1'b1, 5'd0,  64'hFFFF, 5'd0,  5'd0,
                 64'h0, 64'h0, 64'h0, 64'h0};
    vecs[5]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd0,  5'd7,
                 64'h0, 64'hBEEF, 64'hFFFF, 64'hBEEF};
    vecs[6]  = '{1'b1, 5'd3,  64'h1,    1'b0, 5'd0,  64'h0,    5'd3,  5'd0,
                 64'h1, 64'h0, 64'h0, 64'hFFFF};
    vecs[7]  = '{1'b1, 5'd3,  64'h2,    1'b0, 5'd0,  64'h0,    5'd3,  5'd3,
                 64'h2, 64'h2, 64'h1, 64'h1};
    vecs[8]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd3,  5'd9,
                 64'h2, 64'h22, 64'h2, 64'h22};
    vecs[9]  = '{1'b1, 5'd12, 64'hAA,   1'b1, 5'd0,  64'h1234, 5'd0,  5'd12,
                 64'h0, 64'hAA, 64'hFFFF, 64'h0};
    vecs[10] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd0,  5'd12,
                 64'h0, 64'hAA, 64'h1234, 64'hAA};
    vecs[11] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd1, 64'h5, 5'd31, 5'd1,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 64'h0, 64'h0};
    vecs[12] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd31, 5'd1,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5};

    // Reset: hold low for 3 cycles, then measure the sweep window
    rst_n = 1'b0;
    idle_inputs();
    raddr = {5'd7, 5'd5};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready_a", 64'(ready_a), 64'h0);
    chk("reset_ready_b", 64'(ready_b), 64'h0);
    chk("reset_rdata_a0", rdata_a[63:0], 64'h0);
    chk("reset_rdata_a1", rdata_a[127:64], 64'h0);
    rst_n = 1'b1;
    measure_low(n);
    chk("reset_sweep_len", 64'(n), 64'd32);
    chk("reset_ready_b_after", 64'(ready_b), 64'h1);
    raddr = {5'd31, 5'd5};
    #1;
    chk("post_reset_r5", rdata_a[63:0], 64'h0);
    chk("post_reset_r31", rdata_b[127:64], 64'h0);

    // Directed vector table, same-cycle reads checked before the edge
    for (int i = 0; i < 13; i++) begin
      wen0 = vecs[i].wen0; waddr0 = vecs[i].wa0; wdata0 = vecs[i].wd0;
      wen1 = vecs[i].wen1; waddr1 = vecs[i].wa1; wdata1 = vecs[i].wd1;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk($sformatf("vec%0d_a0", i), rdata_a[63:0],   vecs[i].ea0);
      chk($sformatf("vec%0d_a1", i), rdata_a[127:64], vecs[i].ea1);
      chk($sformatf("vec%0d_b0", i), rdata_b[63:0],   vecs[i].eb0);
      chk($sformatf("vec%0d_b1", i), rdata_b[127:64], vecs[i].eb1);
      @(posedge clk);
      @(negedge clk);
    end
    idle_inputs();

    // Fill r1..r31, then clear with a simultaneous write that must be dropped
    for (int i = 1; i < 32; i++) begin
      wen0 = 1'b1; waddr0 = 5'(i); wdata0 = 64'(i) * 64'h101;
      @(posedge clk);
      @(negedge clk);
    end
    clr = 1'b1;
    wen0 = 1'b1; waddr0 = 5'd4; wdata0 = 64'h99;
    raddr = {5'd4, 5'd4};
    #1;
    chk("clr_cycle_a_r4", rdata_a[63:0], 64'h404);
    chk("clr_cycle_b_r4", rdata_b[63:0], 64'h404);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    wen0 = 1'b1; waddr0 = 5'd2; wdata0 = 64'h77;
    raddr = {5'd2, 5'd2};
    #1;
    chk("sweep_rdata_a", rdata_a[63:0], 64'h0);
    chk("sweep_ready_b", 64'(ready_b), 64'h0);
    measure_low(n);
    wen0 = 1'b0;
    chk("clr_sweep_len", 64'(n), 64'd32);
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      #1;
      v = rdata_a[63:0] | rdata_a[127:64] | rdata_b[63:0] | rdata_b[127:64];
      chk($sformatf("cleared_r%0d", i), v, 64'h0);
    end

    // Reset pulse at sweep cycle 10 restarts the full sweep
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midsweep_reset_ready", 64'(ready_a), 64'h0);
    rst_n = 1'b1;
    measure_low(n);
    chk("midsweep_reset_len", 64'(n), 64'd32);
    chk("midsweep_ready_b", 64'(ready_b), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
